// File: rtl/pipe_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor, valid/ready handshake.
// Optional saturation on signed overflow: define PIPE_CLA_ADDER_SAT_EN.
module pipe_cla_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NG  = WIDTH / GROUP;
    localparam int MSB = WIDTH - 1;

    logic             s1_valid;
    logic             s1_adv;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_beff;
    logic             s1_cin;
    logic [NG-1:0]    s1_gg;
    logic [NG-1:0]    s1_pg;

    logic [WIDTH-1:0] beff;
    logic             cin_eff;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    pg;

    logic [WIDTH-1:0] g2;
    logic [WIDTH-1:0] p2;
    logic [NG:0]      cg;
    logic             cc;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] res;
    logic             ovf;

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    always_comb begin
        beff    = in_sub ? ~in_b : in_b;
        cin_eff = in_sub | in_cin;
        g       = in_a & beff;
        p       = in_a ^ beff;
    end

    // Group generate/propagate, folded from the low bit upward.
    always_comb begin
        gg = '0;
        pg = '1;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                gg[k] = g[k*GROUP+j] | (p[k*GROUP+j] & gg[k]);
                pg[k] = pg[k] & p[k*GROUP+j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_beff  <= '0;
            s1_cin   <= 1'b0;
            s1_gg    <= '0;
            s1_pg    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= in_a;
                s1_beff <= beff;
                s1_cin  <= cin_eff;
                s1_gg   <= gg;
                s1_pg   <= pg;
            end
        end
    end

    always_comb begin
        g2    = s1_a & s1_beff;
        p2    = s1_a ^ s1_beff;
        cg    = '0;
        cg[0] = s1_cin;
        for (int k = 0; k < NG; k++) begin
            cg[k+1] = s1_gg[k] | (s1_pg[k] & cg[k]);
        end
    end

    // Ripple inside each group, seeded by the lookahead group carry.
    always_comb begin
        sum = '0;
        cc  = 1'b0;
        for (int k = 0; k < NG; k++) begin
            cc = cg[k];
            for (int j = 0; j < GROUP; j++) begin
                sum[k*GROUP+j] = p2[k*GROUP+j] ^ cc;
                cc = g2[k*GROUP+j] | (p2[k*GROUP+j] & cc);
            end
        end
    end

    always_comb begin
        ovf = (s1_a[MSB] == s1_beff[MSB]) && (sum[MSB] != s1_a[MSB]);
        res = sum;
`ifdef PIPE_CLA_ADDER_SAT_EN
        if (ovf) begin
            res = s1_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= res;
                out_cout <= cg[NG];
                out_ovf  <= ovf;
                out_zero <= (res == '0);
            end
        end
    end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder at WIDTH=16: directed corner
// beats, stall/reset scenarios and a long randomized run.
module tb_pipe_cla_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    pipe_cla_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .out_ovf(out_ovf), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails = 0;
    logic held_v = 1'b0;
    exp_t held;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        exp_t e;
        int   sa, sbv, t, u;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sub) begin
            t = sa - sbv;
            u = int'(a) - int'(b);
            e.cout = (a >= b);
        end else begin
            t = sa + sbv + int'(cin);
            u = int'(a) + int'(b) + int'(cin);
            e.cout = (u > 65535);
        end
        e.sum = u[W-1:0];
        e.ovf = (t > 32767) || (t < -32768);
`ifdef PIPE_CLA_ADDER_SAT_EN
        if (e.ovf) e.sum = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        e.zero = (e.sum == '0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (held_v)
                chk("stall_hold", {out_sum, out_cout, out_ovf, out_zero}, held);
            if (out_ready) begin
                held_v = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_result: got sum %h required none",
                             out_sum);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", {out_sum, out_cout, out_ovf, out_zero}, mon_e);
                end
            end else begin
                held_v = 1'b1;
                held   = {out_sum, out_cout, out_ovf, out_zero};
            end
        end else begin
            held_v = 1'b0;
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input logic ordy,
                        input exp_t e, output logic acc);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_cin    = cin;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 12 && (sb.size() != 0 || out_valid); i++)
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, acc);
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_in_ready"}, in_ready, 1);
        chk({nm, "_outs"}, {out_sum, out_cout, out_ovf, out_zero}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        logic         sub, cin, ordy, acc;
        exp_t         e32;
        int           k, tries;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        #1 rst_n = 1'b1;

        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1,
             exp_t'{16'h0000, 1'b1, 1'b0, 1'b1}, acc);
        chk("first_accept", acc, 1);
        chk("latency_early", out_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_2", out_valid, 1);
        drain();

`ifdef PIPE_CLA_ADDER_SAT_EN
        e32 = exp_t'{16'h7FFF, 1'b0, 1'b1, 1'b0};
`else
        e32 = exp_t'{16'h8000, 1'b0, 1'b1, 1'b0};
`endif
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, e32, acc);
        step(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1,
             exp_t'{16'hFFFE, 1'b0, 1'b0, 1'b0}, acc);
        step(1'b1, 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1,
             exp_t'{16'h0002, 1'b1, 1'b0, 1'b0}, acc);
        step(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1,
             model(16'h8000, 16'h0001, 1'b1, 1'b0), acc);
        drain();

        k = 0;
        for (int i = 0; i < 12; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            ordy = !(i >= 2 && i <= 4);
            step(k < 5, a, b, 1'b0, 1'b1, ordy, model(a, b, 1'b0, 1'b1), acc);
            if (i == 2) chk("stall_in_ready_low", acc, 0);
            if (i == 5) chk("resume_accept", acc, 1);
            if (acc) k++;
        end
        chk("stall_beats_sent", k, 5);
        drain();

        step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0,
             model(16'h1111, 16'h2222, 1'b0, 1'b0), acc);
        step(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0,
             model(16'h3333, 16'h4444, 1'b0, 1'b0), acc);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midreset");
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 16'h00F0, 16'h000F, 1'b0, 1'b1, 1'b1,
             exp_t'{16'h0100, 1'b0, 1'b0, 1'b0}, acc);
        chk("post_reset_accept", acc, 1);
        drain();

        for (int n = 0; n < 10000; n++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            sub = 1'($urandom);
            cin = 1'($urandom);
            tries = 0;
            do begin
                ordy = ($urandom_range(0, 3) != 0);
                step(1'b1, a, b, sub, cin, ordy, model(a, b, sub, cin), acc);
                tries++;
            end while (!acc && tries < 50);
            if (!acc) begin
                checks++;
                fails++;
                $display("FAIL random_accept: got stuck required accept");
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
